// File: rtl/dp_pkg.sv
// Shared types and defaults for the dot-product operand feeder.
// Also imported by the engine-side testbench.
package dp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } dp_state_t;

    localparam int D_PIXEL_N     = 10;
    localparam int D_PIXEL_SIZE  = 10;
    localparam int D_WEIGHT_SIZE = 19;
    localparam int D_PARALLEL    = 2;
    localparam int D_VAL_SIZE    = 26;
    localparam int D_ADDR_W      = 8;
    localparam int D_DP_LATENCY  = 12;

    localparam int PIX_BEAT_W = D_PARALLEL * D_PIXEL_SIZE;
    localparam int WT_BEAT_W  = D_PARALLEL * D_WEIGHT_SIZE;

    function automatic int beats_f(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

endpackage

// File: rtl/dp_operand_feeder_if.sv
// Read port shared by the pixel and weight buffers.
// Data returns one cycle after rd_en.
interface dp_operand_feeder_if
    import dp_pkg::*;
#(
    parameter int ADDR_W = D_ADDR_W,
    parameter int PW     = PIX_BEAT_W,
    parameter int WW     = WT_BEAT_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [ADDR_W-1:0] wt_addr;
    logic [PW-1:0]     pix_rdata;
    logic [WW-1:0]     wt_rdata;

    modport master (
        output rd_en, pix_addr, wt_addr,
        input  pix_rdata, wt_rdata
    );

    modport slave (
        input  rd_en, pix_addr, wt_addr,
        output pix_rdata, wt_rdata
    );
endinterface

// File: rtl/dp_lane_mask.sv
// Flags the lanes of a beat that fall past the end of the vector,
// so the partial last beat feeds zeros into the engine.
module dp_lane_mask
    import dp_pkg::*;
#(
    parameter int PIXEL_N  = D_PIXEL_N,
    parameter int PARALLEL = D_PARALLEL,
    parameter int BW       = 3
) (
    input  logic [BW-1:0]       beat_i,
    output logic [PARALLEL-1:0] zero_o
);
    always_comb begin
        zero_o = '0;
        for (int j = 0; j < PARALLEL; j++) begin
            zero_o[j] = (int'(beat_i) * PARALLEL + j) >= PIXEL_N;
        end
    end
endmodule

// File: rtl/dp_operand_feeder.sv
// Clears the dot-product engine, streams pixel/weight beats from two
// memories, drains the engine pipeline and returns the captured sum.
module dp_operand_feeder
    import dp_pkg::*;
#(
    parameter int PIXEL_N     = D_PIXEL_N,
    parameter int PIXEL_SIZE  = D_PIXEL_SIZE,
    parameter int WEIGHT_SIZE = D_WEIGHT_SIZE,
    parameter int PARALLEL    = D_PARALLEL,
    parameter int VAL_SIZE    = D_VAL_SIZE,
    parameter int ADDR_W      = D_ADDR_W,
    parameter int DP_LATENCY  = D_DP_LATENCY
) (
    input  logic                            clk,
    input  logic                            GlobalReset,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               pix_base,
    input  logic [ADDR_W-1:0]               wt_base,
    output logic                            rd_en,
    output logic [ADDR_W-1:0]               pix_addr,
    output logic [ADDR_W-1:0]               wt_addr,
    input  logic [PARALLEL*PIXEL_SIZE-1:0]  pix_rdata,
    input  logic [PARALLEL*WEIGHT_SIZE-1:0] wt_rdata,
    output logic                            dp_clear,
    output logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels,
    output logic [PARALLEL*WEIGHT_SIZE-1:0] Weights,
    input  logic [VAL_SIZE-1:0]             dp_value,
    output logic [VAL_SIZE-1:0]             result,
    output logic                            result_valid,
    output logic                            busy
);
    localparam int PW    = PARALLEL * PIXEL_SIZE;
    localparam int WW    = PARALLEL * WEIGHT_SIZE;
    localparam int BEATS = beats_f(PIXEL_N, PARALLEL);
    localparam int BW    = $clog2(BEATS + 1);
    localparam int DW    = $clog2(DP_LATENCY + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DP_LATENCY - 1);

    dp_state_t         state_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [BW-1:0]     beat_q;
    logic              vld1_q;
    logic [BW-1:0]     beat1_q;
    logic              plast_q;
    logic [DW-1:0]     drain_q;
    logic              clr_q;
    logic              busy_q;
    logic              rv_q;
    logic [VAL_SIZE-1:0] res_q;
    logic [PW-1:0]     pix_q;
    logic [PW-1:0]     pix_d;
    logic [WW-1:0]     wt_q;
    logic [WW-1:0]     wt_d;
    logic [PARALLEL-1:0] lane_zero;

    // beat1_q tags the word coming back from memory this cycle
    dp_lane_mask #(
        .PIXEL_N  (PIXEL_N),
        .PARALLEL (PARALLEL),
        .BW       (BW)
    ) u_mask (
        .beat_i (beat1_q),
        .zero_o (lane_zero)
    );

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            paddr_q <= '0;
            waddr_q <= '0;
            beat_q  <= '0;
            vld1_q  <= 1'b0;
            beat1_q <= '0;
            plast_q <= 1'b0;
            drain_q <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            vld1_q  <= rd_en_q;
            beat1_q <= beat_q;
            plast_q <= vld1_q && (beat1_q == LAST_BEAT);
            clr_q   <= 1'b0;
            rv_q    <= 1'b0;
            if (rd_en_q) begin
                if (beat_q == LAST_BEAT) begin
                    rd_en_q <= 1'b0;
                end else begin
                    beat_q  <= beat_q + 1'b1;
                    paddr_q <= paddr_q + 1'b1;
                    waddr_q <= waddr_q + 1'b1;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        beat_q  <= '0;
                        paddr_q <= pix_base;
                        waddr_q <= wt_base;
                    end
                end
                S_CLEAR: state_q <= S_STREAM;
                S_STREAM: begin
                    if (plast_q) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        res_q   <= dp_value;
                        rv_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_d = '0;
        wt_d  = '0;
        if (vld1_q) begin
            for (int j = 0; j < PARALLEL; j++) begin
                if (!lane_zero[j]) begin
                    pix_d[j*PIXEL_SIZE +: PIXEL_SIZE] =
                        pix_rdata[j*PIXEL_SIZE +: PIXEL_SIZE];
                    wt_d[j*WEIGHT_SIZE +: WEIGHT_SIZE] =
                        wt_rdata[j*WEIGHT_SIZE +: WEIGHT_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            pix_q <= '0;
            wt_q  <= '0;
        end else begin
            pix_q <= pix_d;
            wt_q  <= wt_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign pix_addr     = paddr_q;
    assign wt_addr      = waddr_q;
    assign dp_clear     = clr_q;
    assign Pixels       = pix_q;
    assign Weights      = wt_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_dp_operand_feeder.sv
// Random-stimulus bench for two feeder instances (PIXEL_N 10 and 9)
// checked against a cycle timeline model and a result scoreboard.
module tb_dp_operand_feeder;
    import dp_pkg::*;

    localparam int B = 5;
    localparam int L = 12;
    localparam int P = 2;

    typedef struct packed {
        logic        rd;
        logic [7:0]  pa;
        logic [7:0]  wa;
        logic        clr;
        logic        bsy;
        logic        rv;
        logic [19:0] pix;
        logic [37:0] wt;
    } exp_t;

    typedef struct packed {
        logic [31:0] t0;
        logic [7:0]  pb;
        logic [7:0]  wb;
    } job_t;

    typedef struct packed {
        logic [31:0] tv;
        logic [25:0] val;
    } sb_t;

    logic        clk;
    logic        GlobalReset;
    logic        start;
    logic [7:0]  pix_base;
    logic [7:0]  wt_base;
    logic [25:0] dp_value;
    logic [1:0]  clr;
    logic [1:0]  rv;
    logic [1:0]  bsy;
    logic [19:0] pix [2];
    logic [37:0] wt  [2];
    logic [25:0] res [2];

    logic [19:0] pmem [256];
    logic [37:0] wmem [256];
    job_t        jobs [$];
    sb_t         sbq  [2][$];
    logic [25:0] res_m [2];
    int          cyc = 0;
    int          free_at = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    dp_operand_feeder_if m0 ();
    dp_operand_feeder_if m1 ();

    dp_operand_feeder #(.PIXEL_N(10)) u0 (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .start        (start),
        .pix_base     (pix_base),
        .wt_base      (wt_base),
        .rd_en        (m0.rd_en),
        .pix_addr     (m0.pix_addr),
        .wt_addr      (m0.wt_addr),
        .pix_rdata    (m0.pix_rdata),
        .wt_rdata     (m0.wt_rdata),
        .dp_clear     (clr[0]),
        .Pixels       (pix[0]),
        .Weights      (wt[0]),
        .dp_value     (dp_value),
        .result       (res[0]),
        .result_valid (rv[0]),
        .busy         (bsy[0])
    );

    dp_operand_feeder #(.PIXEL_N(9)) u1 (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .start        (start),
        .pix_base     (pix_base),
        .wt_base      (wt_base),
        .rd_en        (m1.rd_en),
        .pix_addr     (m1.pix_addr),
        .wt_addr      (m1.wt_addr),
        .pix_rdata    (m1.pix_rdata),
        .wt_rdata     (m1.wt_rdata),
        .dp_clear     (clr[1]),
        .Pixels       (pix[1]),
        .Weights      (wt[1]),
        .dp_value     (dp_value),
        .result       (res[1]),
        .result_valid (rv[1]),
        .busy         (bsy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous read memories, one per instance
    initial begin
        m0.pix_rdata = '0;
        m0.wt_rdata  = '0;
        m1.pix_rdata = '0;
        m1.wt_rdata  = '0;
    end

    always @(posedge clk) begin
        if (m0.rd_en) begin
            m0.pix_rdata <= pmem[m0.pix_addr];
            m0.wt_rdata  <= wmem[m0.wt_addr];
        end
        if (m1.rd_en) begin
            m1.pix_rdata <= pmem[m1.pix_addr];
            m1.wt_rdata  <= wmem[m1.wt_addr];
        end
    end

    function automatic logic [25:0] dpv(input int c);
        logic [31:0] x;
        x = 32'(c) * 32'h9E37_79B1 ^ 32'h5A5A_1234;
        return x[31:6];
    endfunction

    initial begin
        dp_value = '0;
        forever begin
            @(negedge clk);
            dp_value = dpv(cyc);
        end
    end

    // expected outputs at cycle c from the job timeline
    function automatic exp_t model(input int c, input int n);
        exp_t e;
        int   d;
        int   idx;
        logic [7:0] a;
        e = '0;
        if (!GlobalReset) return e;
        foreach (jobs[q]) begin
            d = c - int'(jobs[q].t0);
            if (d >= 1 && d <= 3 + B + L) e.bsy = 1'b1;
            if (d == 1) e.clr = 1'b1;
            if (d >= 1 && d <= B) begin
                e.rd = 1'b1;
                e.pa = jobs[q].pb + 8'(d - 1);
                e.wa = jobs[q].wb + 8'(d - 1);
            end
            if (d >= 3 && d <= 2 + B) begin
                for (int j = 0; j < P; j++) begin
                    idx = (d - 3) * P + j;
                    if (idx < n) begin
                        a = jobs[q].pb + 8'(d - 3);
                        e.pix[j*10 +: 10] = pmem[a][j*10 +: 10];
                        a = jobs[q].wb + 8'(d - 3);
                        e.wt[j*19 +: 19] = wmem[a][j*19 +: 19];
                    end
                end
            end
            if (d == 3 + B + L) e.rv = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s u%0d cyc=%0d got=%0h want=%0h",
                     nm, i, cyc, act, req);
        end
    endtask

    task automatic chk(input int i, input logic rd,
                       input logic [7:0] pa, input logic [7:0] wa,
                       input logic cl, input logic bs, input logic v,
                       input logic [19:0] px, input logic [37:0] w,
                       input logic [25:0] r);
        exp_t e;
        sb_t  s;
        e = model(cyc, (i == 0) ? 10 : 9);
        if (v) begin
            if (sbq[i].size() == 0) begin
                cmp("rv_unexpected", i, 64'(v), 64'(0));
            end else begin
                s = sbq[i].pop_front();
                cmp("rv_cycle", i, 64'(cyc), 64'(s.tv));
                res_m[i] = s.val;
            end
        end
        cmp("ctl", i, 64'({rd, cl, bs, v}), 64'({e.rd, e.clr, e.bsy, e.rv}));
        if (e.rd || !GlobalReset)
            cmp("addr", i, 64'({pa, wa}), 64'({e.pa, e.wa}));
        cmp("pixels", i, 64'(px), 64'(e.pix));
        cmp("weights", i, 64'(w), 64'(e.wt));
        cmp("result", i, 64'(r), 64'(res_m[i]));
    endtask

    always @(negedge clk) begin
        chk(0, m0.rd_en, m0.pix_addr, m0.wt_addr, clr[0], bsy[0], rv[0],
            pix[0], wt[0], res[0]);
        chk(1, m1.rd_en, m1.pix_addr, m1.wt_addr, clr[1], bsy[1], rv[1],
            pix[1], wt[1], res[1]);
    end

    // called at a negedge; start is high for exactly that cycle
    task automatic pulse(input logic [7:0] pb, input logic [7:0] wb);
        job_t j;
        sb_t  s;
        start    = 1'b1;
        pix_base = pb;
        wt_base  = wb;
        if (GlobalReset && cyc >= free_at) begin
            j.t0 = 32'(cyc);
            j.pb = pb;
            j.wb = wb;
            jobs.push_back(j);
            s.tv  = 32'(cyc + 3 + B + L);
            s.val = dpv(cyc + 2 + B + L);
            sbq[0].push_back(s);
            sbq[1].push_back(s);
            free_at = cyc + 4 + B + L;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic rst_zero();
        cmp("rst_async_a", 0,
            64'({m0.rd_en, m0.pix_addr, m0.wt_addr, clr[0], bsy[0], rv[0], res[0]}), 64'(0));
        cmp("rst_async_b", 0, 64'({pix[0], wt[0]}), 64'(0));
        cmp("rst_async_a", 1,
            64'({m1.rd_en, m1.pix_addr, m1.wt_addr, clr[1], bsy[1], rv[1], res[1]}), 64'(0));
        cmp("rst_async_b", 1, 64'({pix[1], wt[1]}), 64'(0));
    endtask

    initial begin
        int t;
        GlobalReset = 1'b0;
        start       = 1'b0;
        pix_base    = '0;
        wt_base     = '0;
        res_m[0]    = '0;
        res_m[1]    = '0;
        for (int i = 0; i < 256; i++) begin
            pmem[i] = 20'($urandom);
            wmem[i] = {6'($urandom), 32'($urandom)};
        end
        for (int i = 0; i < 5; i++) begin
            pmem[16 + i] = '1;
            wmem[32 + i] = '1;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 GlobalReset = 1'b1;
        repeat (2) @(negedge clk);

        t = cyc;
        pulse(8'h10, 8'h20);
        wait_to(t + 4);
        pulse(8'h55, 8'h66);
        wait_to(t + 21);
        pulse(8'hFE, 8'($urandom));
        wait_to(t + 50);

        t = cyc;
        pulse(8'($urandom), 8'($urandom));
        do begin
            @(posedge clk);
            #3;
        end while (cyc != t + 6);
        GlobalReset = 1'b0;
        jobs.delete();
        sbq[0].delete();
        sbq[1].delete();
        res_m[0] = '0;
        res_m[1] = '0;
        free_at  = 0;
        #1 rst_zero();
        @(posedge clk);
        @(posedge clk);
        #3 GlobalReset = 1'b1;
        @(negedge clk);
        pulse(8'($urandom), 8'($urandom));
        wait_to(cyc + 25);

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)
                pulse(8'($urandom), 8'($urandom));
        end
        wait_to(free_at + 3);
        cmp("sb_drain", 0, 64'(sbq[0].size()), 64'(0));
        cmp("sb_drain", 1, 64'(sbq[1].size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
